// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with arbitrary depth, occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a selectable first-word-fall-through read port.
module fifo_sync_param #(
  parameter int BITWIDTH  = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iEnW,
  input  logic                iEnR,
  input  logic                iClr,
  input  logic [BITWIDTH-1:0] iData,
  output logic [BITWIDTH-1:0] oData,
  output logic                oFull,
  output logic                oEmpty,
  output logic                oAlmostFull,
  output logic                oAlmostEmpty,
  output logic [CW-1:0]       oCount,
  output logic                oOverflow,
  output logic                oUnderflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_TH);

  logic [BITWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                wr_acc;
  logic                rd_acc;

  // Requests are qualified against the registered flags only, so no status output
  // ever depends combinationally on iEnW/iEnR.
  assign wr_acc = iEnW & ~oFull;
  assign rd_acc = iEnR & ~oEmpty;

  assign oCount       = count;
  assign oFull        = (count == FULL_CNT);
  assign oEmpty       = (count == '0);
  assign oAlmostFull  = (count >= AF_CNT);
  assign oAlmostEmpty = (count <= AE_CNT);

  // Pointers wrap by explicit compare so non-power-of-two depths never index past the array.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (iClr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oOverflow  <= 1'b0;
      oUnderflow <= 1'b0;
    end else if (iClr) begin
      oOverflow  <= 1'b0;
      oUnderflow <= 1'b0;
    end else begin
      if (iEnW && oFull)  oOverflow  <= 1'b1;
      if (iEnR && oEmpty) oUnderflow <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset and clear; stale words stay hidden behind oEmpty.
  always_ff @(posedge iClk) begin
    if (wr_acc && !iClr) mem[wr_ptr] <= iData;
  end

  generate
    if (FWFT == 0) begin : g_registered
      logic [BITWIDTH-1:0] data_q;

      always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN)      data_q <= '0;
        else if (iClr)   data_q <= '0;
        else if (rd_acc) data_q <= mem[rd_ptr];
      end

      assign oData = data_q;
    end else begin : g_fwft
      assign oData = oEmpty ? '0 : mem[rd_ptr];
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a 16-deep registered-read FIFO and a 5-deep FWFT FIFO share
// one stimulus stream and are compared against queue-based models.
module tb_fifo_sync_param;

  logic       iClk = 1'b0;
  logic       iRstN;
  logic       en_w, en_r, clr;
  logic [7:0] data;

  logic [7:0] d0_data, d1_data;
  logic [4:0] d0_count;
  logic [2:0] d1_count;
  logic d0_full, d0_empty, d0_afull, d0_aempty, d0_ovf, d0_unf;
  logic d1_full, d1_empty, d1_afull, d1_aempty, d1_ovf, d1_unf;

  int tests = 0;
  int failed = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       ovf0, unf0, ovf1, unf1;
  logic [7:0] dout0;

  typedef struct {
    logic       w, r, c;
    logic [7:0] d;
    int         exp_cnt;
    logic [7:0] exp_dat;
    logic       exp_unf;
  } vec_t;
  vec_t vecs[10];

  always #5 iClk = ~iClk;

  fifo_sync_param #(.BITWIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)) dut0 (
    .iClk(iClk), .iRstN(iRstN), .iEnW(en_w), .iEnR(en_r), .iClr(clr), .iData(data),
    .oData(d0_data), .oFull(d0_full), .oEmpty(d0_empty), .oAlmostFull(d0_afull),
    .oAlmostEmpty(d0_aempty), .oCount(d0_count), .oOverflow(d0_ovf), .oUnderflow(d0_unf)
  );

  fifo_sync_param #(.BITWIDTH(8), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1), .FWFT(1)) dut1 (
    .iClk(iClk), .iRstN(iRstN), .iEnW(en_w), .iEnR(en_r), .iClr(clr), .iData(data),
    .oData(d1_data), .oFull(d1_full), .oEmpty(d1_empty), .oAlmostFull(d1_afull),
    .oAlmostEmpty(d1_aempty), .oCount(d1_count), .oOverflow(d1_ovf), .oUnderflow(d1_unf)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    ovf0 = 0; unf0 = 0; ovf1 = 0; unf1 = 0;
    dout0 = 8'h00;
  endtask

  // One clock edge of both FIFOs, expressed as queue push/pop on the pre-edge occupancy.
  task automatic model_edge();
    bit wa, ra;
    if (clr) begin
      model_reset();
    end else begin
      wa = en_w && (q0.size() < 16);
      ra = en_r && (q0.size() > 0);
      if (en_w && !wa) ovf0 = 1;
      if (en_r && !ra) unf0 = 1;
      if (ra) dout0 = q0.pop_front();
      if (wa) q0.push_back(data);
      wa = en_w && (q1.size() < 5);
      ra = en_r && (q1.size() > 0);
      if (en_w && !wa) ovf1 = 1;
      if (en_r && !ra) unf1 = 1;
      if (ra) void'(q1.pop_front());
      if (wa) q1.push_back(data);
    end
  endtask

  task automatic checkOutput();
    cmp("count0",  32'(d0_count),  q0.size());
    cmp("full0",   32'(d0_full),   32'(q0.size() == 16));
    cmp("empty0",  32'(d0_empty),  32'(q0.size() == 0));
    cmp("afull0",  32'(d0_afull),  32'(q0.size() >= 12));
    cmp("aempty0", 32'(d0_aempty), 32'(q0.size() <= 2));
    cmp("ovf0",    32'(d0_ovf),    32'(ovf0));
    cmp("unf0",    32'(d0_unf),    32'(unf0));
    cmp("data0",   32'(d0_data),   32'(dout0));
    cmp("count1",  32'(d1_count),  q1.size());
    cmp("full1",   32'(d1_full),   32'(q1.size() == 5));
    cmp("empty1",  32'(d1_empty),  32'(q1.size() == 0));
    cmp("afull1",  32'(d1_afull),  32'(q1.size() >= 4));
    cmp("aempty1", 32'(d1_aempty), 32'(q1.size() <= 1));
    cmp("ovf1",    32'(d1_ovf),    32'(ovf1));
    cmp("unf1",    32'(d1_unf),    32'(unf1));
    cmp("data1",   32'(d1_data),   (q1.size() == 0) ? 32'h0 : 32'(q1[0]));
  endtask

  // Called at a falling edge: drive, let one rising edge happen, check at the next falling edge.
  task automatic applyStimulus(input logic w, input logic r, input logic c, input logic [7:0] d);
    en_w = w; en_r = r; clr = c; data = d;
    @(posedge iClk);
    model_edge();
    @(negedge iClk);
    checkOutput();
  endtask

  task automatic check_cleared(input string tag);
    cmp({tag, "_count0"}, 32'(d0_count), 0);
    cmp({tag, "_empty0"}, 32'(d0_empty), 1);
    cmp({tag, "_aempty0"}, 32'(d0_aempty), 1);
    cmp({tag, "_afull0"}, 32'(d0_afull), 0);
    cmp({tag, "_full0"}, 32'(d0_full), 0);
    cmp({tag, "_ovf0"}, 32'(d0_ovf), 0);
    cmp({tag, "_unf0"}, 32'(d0_unf), 0);
    cmp({tag, "_data0"}, 32'(d0_data), 0);
    cmp({tag, "_data1"}, 32'(d1_data), 0);
    cmp({tag, "_empty1"}, 32'(d1_empty), 1);
  endtask

  initial begin
    iRstN = 1'b0;
    en_w = 0; en_r = 0; clr = 0; data = 8'h00;
    model_reset();
    repeat (2) @(negedge iClk);
    check_cleared("reset");
    iRstN = 1'b1;
    @(negedge iClk);
    checkOutput();

    // Short directed sequence on the 16-deep registered FIFO.
    vecs[0] = '{1, 0, 0, 8'h11, 1, 8'h00, 0};
    vecs[1] = '{1, 0, 0, 8'h22, 2, 8'h00, 0};
    vecs[2] = '{0, 1, 0, 8'h00, 1, 8'h11, 0};
    vecs[3] = '{1, 1, 0, 8'h33, 1, 8'h22, 0};
    vecs[4] = '{0, 1, 0, 8'h00, 0, 8'h33, 0};
    vecs[5] = '{0, 1, 0, 8'h00, 0, 8'h33, 1};
    vecs[6] = '{1, 1, 0, 8'h44, 1, 8'h33, 1};
    vecs[7] = '{1, 0, 1, 8'h55, 0, 8'h00, 0};
    vecs[8] = '{1, 0, 0, 8'h66, 1, 8'h00, 0};
    vecs[9] = '{0, 1, 0, 8'h00, 0, 8'h66, 0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].d);
      cmp($sformatf("vec%0d_cnt", i), 32'(d0_count), vecs[i].exp_cnt);
      cmp($sformatf("vec%0d_dat", i), 32'(d0_data), 32'(vecs[i].exp_dat));
      cmp($sformatf("vec%0d_unf", i), 32'(d0_unf), 32'(vecs[i].exp_unf));
    end

    // Fill, full collision, drain, empty collision.
    applyStimulus(0, 0, 1, 8'h00);
    for (int i = 1; i <= 16; i++) applyStimulus(1, 0, 0, 8'(i));
    cmp("fill_full", 32'(d0_full), 1);
    cmp("fill_count", 32'(d0_count), 16);
    applyStimulus(1, 1, 0, 8'hEE);
    cmp("fullcol_count", 32'(d0_count), 15);
    cmp("fullcol_ovf", 32'(d0_ovf), 1);
    cmp("fullcol_data", 32'(d0_data), 32'h01);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 1, 0, 8'h00);
      cmp("drain_data", 32'(d0_data), i + 2);
    end
    cmp("drain_empty", 32'(d0_empty), 1);
    applyStimulus(1, 1, 0, 8'h77);
    cmp("emptycol_count", 32'(d0_count), 1);
    cmp("emptycol_unf", 32'(d0_unf), 1);
    cmp("emptycol_data", 32'(d0_data), 32'h10);

    // First-word-fall-through display on the 5-deep instance.
    applyStimulus(0, 0, 1, 8'h00);
    applyStimulus(1, 0, 0, 8'hA5);
    cmp("fwft_show", 32'(d1_data), 32'hA5);
    applyStimulus(0, 0, 0, 8'h00);
    cmp("fwft_hold", 32'(d1_data), 32'hA5);
    applyStimulus(0, 1, 0, 8'h00);
    cmp("fwft_pop_data", 32'(d1_data), 0);
    cmp("fwft_pop_empty", 32'(d1_empty), 1);

    // Clear at count 7 with both sticky flags set, while a write is requested.
    for (int i = 0; i < 17; i++) applyStimulus(1, 0, 0, 8'(8'h80 + i));
    for (int i = 0; i < 17; i++) applyStimulus(0, 1, 0, 8'h00);
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 8'(8'hC0 + i));
    cmp("preclr_count", 32'(d0_count), 7);
    cmp("preclr_ovf", 32'(d0_ovf), 1);
    cmp("preclr_unf", 32'(d0_unf), 1);
    applyStimulus(1, 0, 1, 8'h99);
    check_cleared("clr");

    // Asynchronous reset pulse in the middle of a stream.
    applyStimulus(1, 0, 0, 8'h31);
    applyStimulus(1, 0, 0, 8'h32);
    applyStimulus(1, 1, 0, 8'h33);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(1, 1, 0, 8'h34);
    cmp("prerst_unf", 32'(d0_unf), 1);
    #1 iRstN = 1'b0;
    en_w = 0; en_r = 0; clr = 0;
    #1 model_reset();
    check_cleared("arst");
    checkOutput();
    #1 iRstN = 1'b1;
    @(negedge iClk);

    // Randomised traffic in blocks with varying write/read pressure.
    for (int blk = 0; blk < 10; blk++) begin
      int pw, pr;
      pw = $urandom_range(15, 85);
      pr = $urandom_range(15, 85);
      for (int n = 0; n < 200; n++) begin
        applyStimulus(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
                      ($urandom_range(0, 149) == 0), 8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO: next-generation single-clock FIFO for datapath buffering between producer and consumer stages in the same clock domain. It generalises word width and depth, including non-power-of-two depth. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.

## Interface
- BITWIDTH, 8, data word width (>=1)
- DEPTH, 16, number of entries (>=2, any integer)
- AFULL_TH, 12, oAlmostFull asserted when occupancy >= AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, oAlmostEmpty asserted when occupancy <= AEMPTY_TH (0..DEPTH-1)
- FWFT, 0, 0 = registered read (standard), 1 = first-word-fall-through
- CW (local), $clog2(DEPTH+1), count width
- iClk  in  1  clock, all state on rising edge
- iRstN  in  1  asynchronous active-low reset
- iEnW  in  1  write request
- iEnR  in  1  read request
- iClr  in  1  synchronous clear
- iData  in  BITWIDTH  write data
- oData  out  BITWIDTH  read data
- oFull  out  1  occupancy == DEPTH
- oEmpty  out  1  occupancy == 0
- oAlmostFull  out  1  occupancy >= AFULL_TH
- oAlmostEmpty  out  1  occupancy <= AEMPTY_TH
- oCount  out  CW  current occupancy 0..DEPTH
- oOverflow  out  1  sticky: write attempted while full
- oUnderflow  out  1  sticky: read attempted while empty

## Operation
- Accept rules: write accepted = iEnW & ~oFull; read accepted = iEnR & ~oEmpty. Flags are sampled before the edge. Rejected requests change no pointer, count or data.
- Pointers: wr/rd pointers of $clog2(DEPTH) bits. Each increments on its accept and wraps DEPTH-1 -> 0 (explicit compare, not power-of-two rollover).
- Count: +1 on write-only, -1 on read-only, unchanged on simultaneous write+read or neither. All status flags decode the registered count.
- Storage: DEPTH x BITWIDTH array, written at wr pointer on write accept. Not reset and not cleared.
- FWFT=0: on read accept, oData <= mem[rd_ptr] at the edge. Otherwise oData holds its value.
- FWFT=1: oData = mem[rd_ptr] combinationally while oEmpty=0, and 0 while empty. A read accept pops the displayed word.
- Error flags: oOverflow set on iEnW & oFull; oUnderflow set on iEnR & oEmpty. They remain set until iClr or reset.
- iClr has priority over all requests in the same cycle. It zeroes pointers, count, oOverflow, oUnderflow and (FWFT=0) oData. Requests in that cycle are ignored.

## Timing
- Reset (async, iRstN=0): pointers=0, oCount=0, oEmpty=1, oFull=0, oAlmostEmpty=1 (AEMPTY_TH>=0), oAlmostFull=0, oOverflow=0, oUnderflow=0, oData=0.
- Status flags and oCount change one edge after the causing accept. There is no combinational path from iEnW/iEnR to any status output.
- FWFT=0 read latency: data valid on oData the cycle after the read-accept edge.
- FWFT=1 latency: a word written into an empty FIFO at edge k appears on oData after edge k (write-to-data 1 cycle).
- Full + iEnW + iEnR: read accepted, write rejected, oOverflow set, count -> DEPTH-1.
- Empty + iEnW + iEnR: write accepted, read rejected, oUnderflow set, count -> 1.
- Reset asserted mid-operation clears state immediately. Contents are discarded logically (stale storage is unobservable because oEmpty=1).

## Test plan
- Reset then fill: DEPTH=16, write 0x01..0x10 on 16 consecutive cycles -> oCount 16, oFull=1, oAlmostFull=1 from count 12, oEmpty=0.
- Drain order, FWFT=0: read 16 cycles -> oData 0x01..0x10, each one cycle after its accept; oEmpty=1 after last, oAlmostEmpty=1 from count 2.
- Non-power-of-two wrap: DEPTH=5, stream 20 words with interleaved reads keeping count 1..5 -> output sequence equals input, pointers wrap 4->0 without loss.
- Boundary collisions: full + iEnW=iEnR=1 -> count 15, oOverflow=1, head word read. Empty + both -> count 1, oUnderflow=1, oData unchanged.
- FWFT=1: write 0xA5 into empty FIFO -> oData=0xA5 next cycle with no read. Read -> oData=0, oEmpty=1.
- iClr with iEnW=1 at count 7 and both error flags set -> next cycle count 0, oEmpty=1, flags 0, oData=0; mid-stream iRstN pulse gives the same result asynchronously.
